packet_assembler: RTL and testbench

PACKET_ASSEMBLER -- requirements
Module: packet_assembler

---
 rtl/packet_assembler.sv | 135 +++++++++++++
 tb/tb_packet_assembler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_assembler.sv
// Assembles UART bytes ('W'/'R' + 4 little-endian address bytes [+ 4 data bytes]) into a request.
// Optional inter-byte timeout: define PACKET_ASSEMBLER_TIMEOUT_EN.
module packet_assembler #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        req_valid,
   input  logic        req_ready,
   output logic        req_write,
   output logic [31:0] req_addr,
   output logic [31:0] req_data,
   output logic        cmd_err,
   output logic        ovf_err,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ADDR  = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_ISSUE = 2'd3;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;

   logic [1:0] state;
   logic [1:0] byte_idx;
   logic       timeout_hit;

   // Handshake: req_valid is a pure function of the registered state, so it rises the
   // cycle after the last byte, stays high with stable payload until req_valid && req_ready
   // is seen at a rising edge, and never depends combinationally on req_ready.
   assign req_valid = (state == S_ISSUE);
   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] idle_cnt;
   logic            collecting;

   assign collecting  = (state == S_ADDR) || (state == S_DATA);
   // Fires on the edge where the idle count would reach TIMEOUT_CYCLES.
   assign timeout_hit = collecting && !rx_valid && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (collecting && !rx_valid && !timeout_hit) begin
         idle_cnt <= idle_cnt + 1'b1;
      end else begin
         idle_cnt <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         byte_idx  <= 2'd0;
         req_write <= 1'b0;
         req_addr  <= 32'h0;
         req_data  <= 32'h0;
         cmd_err   <= 1'b0;
         ovf_err   <= 1'b0;
      end else begin
         cmd_err <= 1'b0;
         ovf_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  if (rx_data == CMD_WRITE) begin
                     req_write <= 1'b1;
                     byte_idx  <= 2'd0;
                     state     <= S_ADDR;
                  end else if (rx_data == CMD_READ) begin
                     req_write <= 1'b0;
                     byte_idx  <= 2'd0;
                     state     <= S_ADDR;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
            end
            S_ADDR: begin
               if (rx_valid) begin
                  req_addr[{byte_idx, 3'b000} +: 8] <= rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     if (req_write) begin
                        state <= S_DATA;
                     end else begin
                        req_data <= 32'h0;
                        state    <= S_ISSUE;
                     end
                  end
               end else if (timeout_hit) begin
                  byte_idx <= 2'd0;
                  cmd_err  <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            S_DATA: begin
               if (rx_valid) begin
                  req_data[{byte_idx, 3'b000} +: 8] <= rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     state <= S_ISSUE;
                  end
               end else if (timeout_hit) begin
                  byte_idx <= 2'd0;
                  cmd_err  <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            default: begin
               // Bytes arriving while a request waits are dropped, even on the handshake cycle.
               if (rx_valid) begin
                  ovf_err <= 1'b1;
               end
               if (req_ready) begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_packet_assembler.sv
// Bench for packet_assembler: directed scenarios plus random packets against a queue-based model.
module tb_packet_assembler;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        cmd_err;
   logic        ovf_err;
   logic        busy;
   logic [1:0]  dbg_state;

   packet_assembler #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_data(req_data), .cmd_err(cmd_err),
      .ovf_err(ovf_err), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int exp_cmd = 0;
   int act_cmd = 0;
   int exp_ovf = 0;
   int act_ovf = 0;
   bit rand_ready = 1'b0;

   // Expected request: {write, addr, data}
   logic [64:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic send_packet(input bit write, input logic [31:0] addr, input logic [31:0] data,
                              input int max_gap);
      exp_q.push_back({write, addr, write ? data : 32'h0});
      send_byte(write ? 8'h57 : 8'h52);
      for (int i = 0; i < 4; i++) begin
         idle($urandom_range(0, max_gap));
         send_byte(addr[8*i +: 8]);
      end
      if (write) begin
         for (int i = 0; i < 4; i++) begin
            idle($urandom_range(0, max_gap));
            send_byte(data[8*i +: 8]);
         end
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
      chk({tag, "_req_write"}, 64'(req_write), 64'd0);
      chk({tag, "_req_addr"},  64'(req_addr),  64'd0);
      chk({tag, "_req_data"},  64'(req_data),  64'd0);
      chk({tag, "_cmd_err"},   64'(cmd_err),   64'd0);
      chk({tag, "_ovf_err"},   64'(ovf_err),   64'd0);
      chk({tag, "_busy"},      64'(busy),      64'd0);
   endtask

   // ---------------- ready randomiser ----------------
   always @(posedge clk) begin
      #2;
      if (rand_ready) req_ready = 1'($urandom_range(0, 1));
   end

   // ---------------- monitor / scoreboard ----------------
   bit          prev_pending = 1'b0;
   logic [64:0] prev_req;

   always @(negedge clk) begin
      if (rst) begin
         prev_pending = 1'b0;
      end else begin
         if (cmd_err) act_cmd++;
         if (ovf_err) act_ovf++;
         if (prev_pending) begin
            chk("valid_dropped_without_ready", 64'(req_valid), 64'd1);
            if (req_valid) chk("payload_hold", 64'({req_write, req_addr, req_data}), 64'(prev_req));
         end
         if (req_valid && req_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_request", 64'd1, 64'd0);
            end else begin
               logic [64:0] e;
               e = exp_q.pop_front();
               chk("req_write", 64'(req_write), 64'(e[64]));
               chk("req_addr",  64'(req_addr),  64'(e[63:32]));
               chk("req_data",  64'(req_data),  64'(e[31:0]));
            end
         end
         prev_pending = req_valid && !req_ready;
         prev_req     = {req_write, req_addr, req_data};
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0]  b0, b1, b2, b3;
      logic [31:0] d;
      int          vcnt;

      rst = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      req_ready = 1'b0;
      idle(2);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // Minimum-latency write
      req_ready = 1'b1;
      send_packet(1'b1, 32'h12345678, 32'hDEADBEEF, 0);
      @(negedge clk);
      chk("lat_valid_n1", 64'(req_valid), 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("lat_valid_n2", 64'(req_valid), 64'd0);
      chk("lat_busy_n2", 64'(busy), 64'd0);
      wait_drain();

      // Read with 5 stall cycles: valid held 6 cycles
      req_ready = 1'b0;
      send_packet(1'b0, 32'h80001000, 32'h0, 0);
      vcnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (req_valid) vcnt++;
         @(posedge clk);
         #1;
      end
      req_ready = 1'b1;
      @(negedge clk);
      if (req_valid) vcnt++;
      @(posedge clk);
      #1;
      req_ready = 1'b0;
      @(negedge clk);
      chk("read_valid_cycles", 64'(vcnt), 64'd6);
      chk("read_valid_after", 64'(req_valid), 64'd0);
      wait_drain();

      // Unknown command in IDLE
      req_ready = 1'b1;
      send_byte(8'h41);
      exp_cmd++;
      @(negedge clk);
      chk("cmd_err_pulse", 64'(cmd_err), 64'd1);
      chk("cmd_err_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("cmd_err_single", 64'(cmd_err), 64'd0);
      send_packet(1'b0, 32'hCAFE0042, 32'h0, 1);
      wait_drain();

      // Byte during ISSUE with ready low
      req_ready = 1'b0;
      send_packet(1'b1, 32'hA5A5_0F0F, 32'h1357_9BDF, 0);
      send_byte(8'h99);
      exp_ovf++;
      @(negedge clk);
      chk("ovf_pulse", 64'(ovf_err), 64'd1);
      chk("ovf_addr_kept", 64'(req_addr), 64'hA5A5_0F0F);
      chk("ovf_data_kept", 64'(req_data), 64'h1357_9BDF);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("ovf_single", 64'(ovf_err), 64'd0);
      @(posedge clk);
      #1;
      req_ready = 1'b1;
      wait_drain();

      // Byte on the handshake cycle is dropped, not a new command
      req_ready = 1'b1;
      send_packet(1'b0, 32'h0000_5757, 32'h0, 0);
      send_byte(8'h57);
      exp_ovf++;
      @(negedge clk);
      chk("hs_ovf_pulse", 64'(ovf_err), 64'd1);
      chk("hs_not_command", 64'(busy), 64'd0);
      wait_drain();

      // Reset after three address bytes
      send_byte(8'h57);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("midreset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_packet(1'b1, 32'h0BAD_F00D, 32'h600D_CAFE, 0);
      wait_drain();

      // Inter-byte idle gap of 16 cycles
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      d = $urandom;
      send_byte(8'h57);
      send_byte(b0);
      send_byte(b1);
      idle(16);
      @(negedge clk);
`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
      exp_cmd++;
      chk("timeout_cmd_err", 64'(cmd_err), 64'd1);
      chk("timeout_busy", 64'(busy), 64'd0);
      idle(4);
      chk("timeout_no_valid", 64'(req_valid), 64'd0);
`else
      chk("no_timeout_busy", 64'(busy), 64'd1);
      exp_q.push_back({1'b1, b3, b2, b1, b0, d});
      @(posedge clk);
      #1;
      send_byte(b2);
      send_byte(b3);
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
      wait_drain();
`endif

      // Random packets with random ready and bad command bytes
      rand_ready = 1'b1;
      for (int p = 0; p < 40; p++) begin
         send_packet(1'($urandom_range(0, 1)), $urandom, $urandom, 3);
         wait_drain();
         if ($urandom_range(0, 3) == 0) begin
            logic [7:0] bad;
            bad = 8'($urandom);
            if (bad == 8'h57 || bad == 8'h52) bad = 8'hFF;
            send_byte(bad);
            exp_cmd++;
            idle(1);
         end
      end
      rand_ready = 1'b0;
      idle(3);

      chk("cmd_err_total", 64'(act_cmd), 64'(exp_cmd));
      chk("ovf_err_total", 64'(act_ovf), 64'(exp_ovf));
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
